// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, bubble instruction, opcode map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,   // request on the bus, waiting for grant
        S_WAIT = 2'd1,   // granted, waiting for the response
        S_FULL = 2'd2,   // response parked in the skid buffer behind a stalled IF/ID
        S_DROP = 2'd3    // redirected while a response is still owed; swallow it
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes consumed by the main controller
    localparam logic [6:0] OPC_R    = 7'h33;
    localparam logic [6:0] OPC_I    = 7'h13;
    localparam logic [6:0] OPC_U    = 7'h37;
    localparam logic [6:0] OPC_LW   = 7'h03;
    localparam logic [6:0] OPC_SW   = 7'h23;
    localparam logic [6:0] OPC_BR   = 7'h63;
    localparam logic [6:0] OPC_JAL  = 7'h6F;
    localparam logic [6:0] OPC_JALR = 7'h67;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,instr} holding register for a response that arrives while IF/ID is stalled.
// Latency: loaded value visible the cycle after load; clear wins over load.
// Backpressure: none of its own; the fetch FSM only loads it when it is empty.
// Ports: clk, reset (async, active-high); load/load_pc/load_instr capture an entry;
//        clear empties it; valid/pc/instr present the held entry.
module fetch_skid_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register; single outstanding imem request, branch/jump redirect.
// Latency: one instruction per (grant latency + response latency) cycles; IF/ID loads on rvalid edge.
// Backpressure: id_stall freezes IF/ID; a response landing during a stall parks in a 1-entry skid.
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata to
//        instruction memory; id_stall, redirect_valid/redirect_pc from decode/execute;
//        if_id_valid/if_id_pc/if_id_instr/if_id_opcode to decode.
// Option: define IF_PERF_COUNTERS_EN to add perf_fetched / perf_flushed event counters.
module if_fetch_stage #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [6:0]      if_id_opcode
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);
    import fetch_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic            vld_d;
    logic [XLEN-1:0] id_pc_d;
    logic [31:0]     instr_d;

    logic            load_en;
    logic [XLEN-1:0] load_pc;
    logic [31:0]     load_instr;

    logic            skid_load, skid_clear, skid_vld;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;

    logic            resp_owed;   // a granted request will still answer after this edge
    logic            discard;     // redirect throws away real work

    assign pc_plus4     = pc_q + XLEN'(4);   // wraps naturally
    assign imem_req     = (state_q == S_REQ) && !reset;
    assign imem_addr    = pc_q;
    assign if_id_opcode = opcode_of(if_id_instr);

    assign resp_owed = (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid)
                     || ((state_q == S_REQ) && imem_gnt);
    assign discard   = redirect_valid && (if_id_valid || (state_q == S_FULL)
                     || (state_q == S_WAIT) || ((state_q == S_REQ) && imem_gnt));

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_pc    (pc_q),
        .load_instr (imem_rdata),
        .valid      (skid_vld),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        vld_d      = if_id_valid;
        id_pc_d    = if_id_pc;
        instr_d    = if_id_instr;
        load_en    = 1'b0;
        load_pc    = pc_q;
        load_instr = imem_rdata;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        case (state_q)
            S_REQ: begin
                if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // IF/ID is free if empty or being consumed this very cycle
                    if (!if_id_valid || !id_stall) begin
                        load_en = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = S_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (!id_stall && skid_vld) begin
                    load_en    = 1'b1;
                    load_pc    = skid_pc;
                    load_instr = skid_instr;
                    skid_clear = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (load_en) begin
            vld_d   = 1'b1;
            id_pc_d = load_pc;
            instr_d = load_instr;
        end else if (if_id_valid && !id_stall) begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
        end

        // Redirect overrides everything above, including a stall
        if (redirect_valid) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            vld_d      = 1'b0;
            instr_d    = NOP_INSTR;
            load_en    = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = resp_owed ? S_DROP : S_REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_id_valid <= vld_d;
            if_id_pc    <= id_pc_d;
            if_id_instr <= instr_d;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (load_en) perf_fetched <= perf_fetched + 32'd1;
            if (discard) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed literal scenarios, then randomized memory/stall/redirect
// traffic checked every cycle against a transaction-level model of the fetch stage.
// A second instance with RESET_PC at the top of the address space checks PC wrap.
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_instr;
    logic [6:0]  if_id_opcode;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b0, w_rvalid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_vld;
    logic [31:0] w_pc, w_instr;
    logic [6:0]  w_opc;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_flushed, w_pfetch, w_pflush;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_opcode(if_id_opcode)
`ifdef IF_PERF_COUNTERS_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .id_stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .if_id_valid(w_vld), .if_id_pc(w_pc), .if_id_instr(w_instr),
        .if_id_opcode(w_opc)
`ifdef IF_PERF_COUNTERS_EN
        , .perf_fetched(w_pfetch), .perf_flushed(w_pflush)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_out    = 0;   // a granted request has not yet answered
    bit          m_drop   = 0;   // that answer belongs to a flushed path
    bit          m_skid_v = 0;
    logic [31:0] m_skid_pc = '0, m_skid_i = '0;
    bit          m_v      = 0;
    logic [31:0] m_pc     = '0, m_instr = NOP;
    logic [31:0] m_fpc    = '0;  // next fetch address
    logic [31:0] m_nfetch = '0, m_nflush = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_out = 0; m_drop = 0; m_skid_v = 0; m_v = 0;
                m_pc = '0; m_instr = NOP; m_fpc = '0; m_nfetch = '0; m_nflush = '0;
            end else begin
                bit          req, got, keep;
                logic [31:0] d, dpc;
                req = !m_out && !m_skid_v;
                got = 0; d = '0; dpc = '0;
                if (redirect_valid) begin
                    if (m_v || m_skid_v || (m_out && !m_drop) || (req && imem_gnt))
                        m_nflush = m_nflush + 1;
                    keep     = (m_out && !imem_rvalid) || (req && imem_gnt);
                    m_out    = keep;
                    m_drop   = keep;
                    m_skid_v = 0;
                    m_v      = 0;
                    m_instr  = NOP;
                    m_fpc    = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (m_out && imem_rvalid) begin
                        if (!m_drop) begin got = 1; d = imem_rdata; dpc = m_fpc; end
                        m_out = 0; m_drop = 0;
                    end else if (req && imem_gnt) begin
                        m_out = 1; m_drop = 0;
                    end
                    if (got && (!m_v || !id_stall)) begin
                        m_v = 1; m_pc = dpc; m_instr = d; m_fpc = m_fpc + 4;
                        m_nfetch = m_nfetch + 1;
                    end else if (got) begin
                        m_skid_v = 1; m_skid_pc = dpc; m_skid_i = d;
                    end else if (m_skid_v && !id_stall) begin
                        m_v = 1; m_pc = m_skid_pc; m_instr = m_skid_i; m_fpc = m_fpc + 4;
                        m_skid_v = 0; m_nfetch = m_nfetch + 1;
                    end else if (m_v && !id_stall) begin
                        m_v = 0; m_instr = NOP;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            logic exp_req;
            @(negedge clk);
            exp_req = !reset && !m_out && !m_skid_v;
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, m_fpc);
            chk("if_id_valid", if_id_valid, m_v);
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_opcode", if_id_opcode, m_instr[6:0]);
            if (m_v) chk("if_id_pc", if_id_pc, m_pc);
`ifdef IF_PERF_COUNTERS_EN
            chk("perf_fetched", perf_fetched, m_nfetch);
            chk("perf_flushed", perf_flushed, m_nflush);
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit       pending, last_gnt;
        int unsigned delay;
        pending = 0; last_gnt = 0; delay = 0;

        #1 reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pc", if_id_pc, 0);
        chk("rst_addr", imem_addr, 0);

        // 1: release with grant in the same cycle, response one cycle later
        tick(); reset = 1'b0; imem_gnt = 1'b1; w_gnt = 1'b1;
        @(negedge clk);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        tick(); imem_gnt = 1'b0; w_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        w_rvalid = 1'b1; w_rdata = 32'h0050_0093;
        tick(); imem_rvalid = 1'b0; w_rvalid = 1'b0;
        imem_gnt = 1'b1; id_stall = 1'b1;          // start of test 2
        @(negedge clk);
        chk("t1_valid", if_id_valid, 1);
        chk("t1_pc", if_id_pc, 0);
        chk("t1_opcode", if_id_opcode, 7'h13);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t5_wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("t5_wrap_addr", w_addr, 32'h0);

        // 2: stall for three cycles while the next response returns
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("t2_held_instr", if_id_instr, 32'h0050_0093);
        chk("t2_held_valid", if_id_valid, 1);
        chk("t2_no_req", imem_req, 0);
        tick(); id_stall = 1'b0;
        tick(); imem_gnt = 1'b1;                    // start of test 3
        @(negedge clk);
        chk("t2_instr", if_id_instr, 32'h0000_0033);
        chk("t2_pc", if_id_pc, 32'h4);
        chk("t2_addr", imem_addr, 32'h8);

        // 3: redirect while waiting for a response
        tick(); imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("t3_drop_req", imem_req, 0);
        chk("t3_valid", if_id_valid, 0);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("t3_after_valid", if_id_valid, 0);
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h100);

        // 4: redirect and response in the same cycle
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); imem_rvalid = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_valid", if_id_valid, 0);
        chk("t4_instr", if_id_instr, NOP);

        // PC wrap reached through a redirect that retargets a pending request
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_retarget_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_006F;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_opcode", if_id_opcode, 7'h6F);
        chk("wrap_addr", imem_addr, 32'h0);

        // 6: reset mid-transaction, stale response afterwards
        tick(); imem_gnt = 1'b1;
        tick(); imem_gnt = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("t6_req_in_reset", imem_req, 0);
        tick(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA;
        tick(); imem_rvalid = 1'b0;
        @(negedge clk);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_valid", if_id_valid, 0);
`ifdef IF_PERF_COUNTERS_EN
        chk("t6_perf_fetched", perf_fetched, 0);
        chk("t6_perf_flushed", perf_flushed, 0);
`endif

        // randomized traffic
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (last_gnt) begin
                pending = 1;
                delay   = $urandom_range(0, 3);
            end
            imem_rvalid = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    imem_rvalid = 1'b1;
                    pending     = 0;
                end else begin
                    delay = delay - 1;
                end
            end
            imem_rdata     = $urandom;
            id_stall       = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            reset          = ($urandom_range(0, 299) == 0);
            imem_gnt       = !reset && imem_req && !pending && ($urandom_range(0, 2) != 0);
            last_gnt       = imem_gnt;
        end

        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; id_stall = 1'b0;
        redirect_valid = 1'b0; reset = 1'b0;
        tick(); tick();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
